branch_sequencer: RTL

- Control sequencer for the conditional-branch instruction class (brzr, brnz, brpl, brmi).
- Sits directly upstream of the datapath and drives its register-transfer strobes through fetch (T0–T2) and branch execute (T3–T6).
- Contains the CON flip-flop. In T3 the flip-flop evaluates the bus value against the IR C2 field, and T6 uses the latched result to gate PCin.
- A datapath bench can run a branch instruction from a single start pulse instead of hand-driving every step.

---
 rtl/branch_sequencer_pkg.sv | 61 ++++++
 rtl/branch_sequencer_if.sv | 27 ++
 rtl/branch_sequencer_con_ff_logic.sv | 33 +++
 rtl/branch_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the conditional-branch control sequencer.
// Holds the state encoding, opcodes, C2 condition codes and the strobe bundle.
package branch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_T6   = 3'd7
    } state_t;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_ST  = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_BR  = 5'b10010;

    typedef enum logic [1:0] {
        CZR = 2'b00,
        CNZ = 2'b01,
        CPL = 2'b10,
        CMI = 2'b11
    } cond_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic zlow_in;
        logic zlow_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic gra;
        logic r_out;
        logic y_in;
        logic c_out;
        logic add;
        logic con_in;
        logic busy;
        logic done;
        logic illegal;
    } strobes_t;

    // Branch condition from the bus summary bits (zero flag and sign bit).
    function automatic logic cond_met(input cond_t cond, input logic is_zero,
                                      input logic is_neg);
        case (cond)
            CZR:     return is_zero;
            CNZ:     return !is_zero;
            CPL:     return !is_neg;
            default: return is_neg;
        endcase
    endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Datapath-facing signal bundle of the branch sequencer.
// The master side (datapath or bench) drives start/ir/bus_in; the sequencer drives the strobes.
interface branch_sequencer_if #(parameter int DATA_WIDTH = 32);

    logic                  start;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] bus_in;

    logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin;
    logic MDRout, IRin, Gra, Rout, Yin, Cout, ADD, con_in;
    logic con_out, busy, done, illegal;

    modport master (
        output start, ir, bus_in,
        input  PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin,
        input  MDRout, IRin, Gra, Rout, Yin, Cout, ADD, con_in,
        input  con_out, busy, done, illegal
    );

    modport slave (
        input  start, ir, bus_in,
        output PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MDRin,
        output MDRout, IRin, Gra, Rout, Yin, Cout, ADD, con_in,
        output con_out, busy, done, illegal
    );

endinterface

// File: rtl/branch_sequencer_con_ff_logic.sv
// CON flip-flop: decodes the C2 condition against the bus and latches the
// result when con_in is asserted; holds otherwise.
module con_ff_logic
    import branch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [1:0]            cond,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  con_in,
    output logic                  con_out
);

    logic con_reg;
    logic bus_zero;
    logic con_next;

    assign bus_zero = (bus_in == '0);
    assign con_next = cond_met(cond_t'(cond), bus_zero, bus_in[DATA_WIDTH-1]);

    always_ff @(posedge clock) begin
        if (clear) begin
            con_reg <= 1'b0;
        end else if (con_in) begin
            con_reg <= con_next;
        end
    end

    assign con_out = con_reg;

endmodule

// File: rtl/branch_sequencer.sv
// Fetch + conditional-branch execute sequencer. Strobes are a Moore decode of
// the state register, refined in T3/T6 by the IR opcode and the CON flip-flop.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter logic [4:0] BR_OPCODE  = OP_BR
) (
    input  logic                clock,
    input  logic                clear,
    branch_sequencer_if.slave   sif
);

    state_t   state_reg;
    strobes_t strobes;
    logic     opcode_match;
    logic     con_out;

    assign opcode_match = (sif.ir[31:27] == BR_OPCODE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (sif.start) state_reg <= ST_T0;
                ST_T0:   state_reg <= ST_T1;
                ST_T1:   state_reg <= ST_T2;
                ST_T2:   state_reg <= ST_T3;
                ST_T3:   state_reg <= opcode_match ? ST_T4 : ST_IDLE;
                ST_T4:   state_reg <= ST_T5;
                ST_T5:   state_reg <= ST_T6;
                ST_T6:   state_reg <= sif.start ? ST_T0 : ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        strobes      = '0;
        strobes.busy = (state_reg != ST_IDLE);
        case (state_reg)
            ST_T0: begin
                strobes.pc_out  = 1'b1;
                strobes.mar_in  = 1'b1;
                strobes.inc_pc  = 1'b1;
                strobes.zlow_in = 1'b1;
            end
            ST_T1: begin
                strobes.zlow_out = 1'b1;
                strobes.pc_in    = 1'b1;
                strobes.read     = 1'b1;
                strobes.mdr_in   = 1'b1;
            end
            ST_T2: begin
                strobes.mdr_out = 1'b1;
                strobes.ir_in   = 1'b1;
            end
            ST_T3: begin
                strobes.gra     = opcode_match;
                strobes.r_out   = opcode_match;
                strobes.con_in  = opcode_match;
                strobes.illegal = !opcode_match;
            end
            ST_T4: begin
                strobes.pc_out = 1'b1;
                strobes.y_in   = 1'b1;
            end
            ST_T5: begin
                strobes.c_out   = 1'b1;
                strobes.add     = 1'b1;
                strobes.zlow_in = 1'b1;
            end
            ST_T6: begin
                // The branch is taken only if CON latched true back in T3.
                strobes.zlow_out = 1'b1;
                strobes.done     = 1'b1;
                strobes.pc_in    = con_out;
            end
            default: ;
        endcase
    end

    con_ff_logic #(.DATA_WIDTH(DATA_WIDTH)) u_con_ff (
        .clock   (clock),
        .clear   (clear),
        .cond    (sif.ir[20:19]),
        .bus_in  (sif.bus_in),
        .con_in  (strobes.con_in),
        .con_out (con_out)
    );

    assign sif.PCout   = strobes.pc_out;
    assign sif.MARin   = strobes.mar_in;
    assign sif.IncPC   = strobes.inc_pc;
    assign sif.Zlowin  = strobes.zlow_in;
    assign sif.Zlowout = strobes.zlow_out;
    assign sif.PCin    = strobes.pc_in;
    assign sif.Read    = strobes.read;
    assign sif.MDRin   = strobes.mdr_in;
    assign sif.MDRout  = strobes.mdr_out;
    assign sif.IRin    = strobes.ir_in;
    assign sif.Gra     = strobes.gra;
    assign sif.Rout    = strobes.r_out;
    assign sif.Yin     = strobes.y_in;
    assign sif.Cout    = strobes.c_out;
    assign sif.ADD     = strobes.add;
    assign sif.con_in  = strobes.con_in;
    assign sif.busy    = strobes.busy;
    assign sif.done    = strobes.done;
    assign sif.illegal = strobes.illegal;
    assign sif.con_out = con_out;

endmodule
